// File: rtl/uart_tx_protocol_if.sv
// Host-side transmit bus for the command-link UART transmitter.
// The host drives configuration and push requests; the transmitter drives line and status.
interface uart_tx_protocol_if;
  logic [15:0] baud_div;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        clr_ovf;
  logic        TX;
  logic        tx_done;
  logic        busy;
  logic        full;
  logic        ovf;

  modport master (
    output baud_div, trmt, tx_data, clr_ovf,
    input  TX, tx_done, busy, full, ovf
  );

  modport slave (
    input  baud_div, trmt, tx_data, clr_ovf,
    output TX, tx_done, busy, full, ovf
  );
endinterface

// File: rtl/uart_tx_protocol.sv
// UART transmitter: byte FIFO feeding a 10-bit frame serialiser (start 0, 8 data LSB first, stop 1).
// Bit period is baud_div+1 clocks, latched per frame; frames queued in the FIFO go out back to back.
module uart_tx_protocol #(
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_protocol_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, XMIT} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [9:0]    sr;
  logic [15:0]   div_q;
  logic [15:0]   baud_cnt;
  logic [3:0]    bit_cnt;
  logic          tx_q;
  logic          tx_done_q;
  logic          ovf_q;

  logic full;
  logic not_empty;
  logic push;
  logic bit_end;
  logic frame_end;
  logic load;

  // full is taken from the pre-edge count, so a pop in the same cycle never rescues a push
  assign full      = (count == FULL_CNT);
  assign not_empty = (count != '0);
  assign push      = bus.trmt & ~full;
  assign bit_end   = (state == XMIT) && (baud_cnt == div_q);
  assign frame_end = bit_end && (bit_cnt == 4'd9);
  assign load      = not_empty && ((state == IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.trmt && full) ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end

  // Frame data and divisor are only meaningful in XMIT, so they carry no reset
  always_ff @(posedge clk) begin
    if (load) begin
      sr    <= {1'b1, mem[rd_ptr], 1'b0};
      div_q <= bus.baud_div;
    end else if (bit_end) begin
      sr    <= {1'b1, sr[9:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= frame_end;
      tx_q      <= (state == XMIT) ? sr[0] : 1'b1;
      case (state)
        IDLE: begin
          if (load) begin
            state    <= XMIT;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        XMIT: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (frame_end) begin
              bit_cnt <= '0;
              if (!load) state <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.TX      = tx_q;
  assign bus.tx_done = tx_done_q;
  assign bus.busy    = (state == XMIT) | not_empty;
  assign bus.full    = full;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_uart_tx_protocol.sv
// Directed bench for uart_tx_protocol: line activity is logged per clock and frames are
// compared bit by bit against hand-derived frame contents and timing.
module tb_uart_tx_protocol;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   e0;
  int   r0;
  int   bad;

  logic txlog   [4096];
  logic donelog [4096];
  logic busylog [4096];

  uart_tx_protocol_if bus();

  uart_tx_protocol #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Value seen after edge N is stored at index N
  always @(negedge clk) begin
    if (cyc < 4096) begin
      txlog[cyc]   <= bus.TX;
      donelog[cyc] <= bus.tx_done;
      busylog[cyc] <= bus.busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.trmt    = 1'b1;
    bus.tx_data = b;
    step();
    bus.trmt    = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < max) begin
      step();
      n++;
    end
    chk(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  // Frame = start 0, data LSB first, stop 1, each held d+1 clocks; tx_done only on the
  // final clock of the stop bit, where busy also drops if this is the last queued frame.
  task automatic check_frame(input string tag, input int start, input logic [7:0] b,
                             input int d, input bit last);
    int   bad_done;
    int   bad_busy;
    int   bad_bit;
    int   idx;
    logic e;
    logic e_done;
    logic e_busy;
    bad_done = 0;
    bad_busy = 0;
    for (int k = 0; k < 10; k++) begin
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      bad_bit = 0;
      for (int j = 0; j <= d; j++) begin
        idx    = start + k*(d+1) + j;
        e_done = (k == 9 && j == d);
        e_busy = !(last && k == 9 && j == d);
        if (txlog[idx] !== e) bad_bit++;
        if (donelog[idx] !== e_done) bad_done++;
        if (busylog[idx] !== e_busy) bad_busy++;
      end
      chk($sformatf("%s_bit%0d_badclks", tag, k), bad_bit, 0);
    end
    chk($sformatf("%s_txdone_badclks", tag), bad_done, 0);
    chk($sformatf("%s_busy_badclks", tag), bad_busy, 0);
  endtask

  task automatic check_idle(input string tag, input int idx);
    chk($sformatf("%s_tx", tag), {31'd0, txlog[idx]}, 32'd1);
    chk($sformatf("%s_busy", tag), {31'd0, busylog[idx]}, 32'd0);
    chk($sformatf("%s_done", tag), {31'd0, donelog[idx]}, 32'd0);
  endtask

  initial begin
    bus.baud_div = 16'd15;
    bus.trmt     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.clr_ovf  = 1'b0;
    steps(3);
    chk("rst_tx",      {31'd0, bus.TX},      32'd1);
    chk("rst_tx_done", {31'd0, bus.tx_done}, 32'd0);
    chk("rst_busy",    {31'd0, bus.busy},    32'd0);
    chk("rst_full",    {31'd0, bus.full},    32'd0);
    chk("rst_ovf",     {31'd0, bus.ovf},     32'd0);
    rst_n = 1'b1;
    steps(2);

    // Single frame 0xA5 at 16 clocks per bit
    bus.baud_div = 16'd15;
    push(8'hA5);
    e0 = cyc;
    chk("t1_busy_e0", {31'd0, bus.busy}, 32'd1);
    chk("t1_tx_e0",   {31'd0, bus.TX},   32'd1);
    step();
    chk("t1_tx_e1",   {31'd0, bus.TX},   32'd1);
    step();
    chk("t1_tx_e2",   {31'd0, bus.TX},   32'd0);
    wait_idle("t1_idle", 400);
    steps(3);
    check_frame("t1", e0 + 2, 8'hA5, 15, 1'b1);
    check_idle("t1_after", e0 + 2 + 160);

    // Three back-to-back frames at 4 clocks per bit
    bus.baud_div = 16'd3;
    bus.trmt = 1'b1; bus.tx_data = 8'h00; step();
    e0 = cyc;
    bus.tx_data = 8'hFF; step();
    bus.tx_data = 8'h3C; step();
    bus.trmt = 1'b0;
    wait_idle("t2_idle", 400);
    steps(3);
    check_frame("t2a", e0 + 2,  8'h00, 3, 1'b0);
    check_frame("t2b", e0 + 42, 8'hFF, 3, 1'b0);
    check_frame("t2c", e0 + 82, 8'h3C, 3, 1'b1);
    check_idle("t2_after", e0 + 122);

    // Overflow: fill FIFO behind an in-flight frame, then keep pushing through the pop edge
    bus.baud_div = 16'd0;
    bus.trmt = 1'b1; bus.tx_data = 8'h55; step();
    e0 = cyc;
    bus.tx_data = 8'h01; step();
    bus.tx_data = 8'h80; step();
    bus.tx_data = 8'hC3; step();
    chk("t3_ovf_clear_before", {31'd0, bus.ovf}, 32'd0);
    bus.tx_data = 8'h7E; step();
    chk("t3_full_e4", {31'd0, bus.full}, 32'd1);
    bus.tx_data = 8'hEE; step();
    chk("t3_ovf_set", {31'd0, bus.ovf}, 32'd1);
    bus.clr_ovf = 1'b1; step();
    chk("t3_ovf_set_beats_clr", {31'd0, bus.ovf}, 32'd1);
    bus.clr_ovf = 1'b0;
    while (cyc < e0 + 11) step();
    chk("t3_full_after_pop_edge", {31'd0, bus.full}, 32'd0);
    chk("t3_ovf_still", {31'd0, bus.ovf}, 32'd1);
    bus.trmt = 1'b0; bus.clr_ovf = 1'b1; step();
    chk("t3_ovf_cleared", {31'd0, bus.ovf}, 32'd0);
    bus.clr_ovf = 1'b0;
    wait_idle("t3_idle", 200);
    steps(3);
    check_frame("t3_55", e0 + 2,  8'h55, 0, 1'b0);
    check_frame("t3_01", e0 + 12, 8'h01, 0, 1'b0);
    check_frame("t3_80", e0 + 22, 8'h80, 0, 1'b0);
    check_frame("t3_c3", e0 + 32, 8'hC3, 0, 1'b0);
    check_frame("t3_7e", e0 + 42, 8'h7E, 0, 1'b1);
    check_idle("t3_after", e0 + 52);

    // Push coinciding with pop at occupancy 2 keeps occupancy at 2
    bus.baud_div = 16'd1;
    bus.trmt = 1'b1; bus.tx_data = 8'h12; step();
    e0 = cyc;
    bus.tx_data = 8'h34; step();
    bus.tx_data = 8'h56; step();
    bus.trmt = 1'b0;
    while (cyc < e0 + 20) step();
    bus.trmt = 1'b1; bus.tx_data = 8'h78; step();
    chk("t4_full_e21", {31'd0, bus.full}, 32'd0);
    bus.tx_data = 8'h9A; step();
    chk("t4_full_e22", {31'd0, bus.full}, 32'd0);
    bus.tx_data = 8'hBC; step();
    chk("t4_full_e23", {31'd0, bus.full}, 32'd1);
    bus.trmt = 1'b0;
    wait_idle("t4_idle", 400);
    steps(3);
    check_frame("t4_12", e0 + 2,   8'h12, 1, 1'b0);
    check_frame("t4_34", e0 + 22,  8'h34, 1, 1'b0);
    check_frame("t4_56", e0 + 42,  8'h56, 1, 1'b0);
    check_frame("t4_78", e0 + 62,  8'h78, 1, 1'b0);
    check_frame("t4_9a", e0 + 82,  8'h9A, 1, 1'b0);
    check_frame("t4_bc", e0 + 102, 8'hBC, 1, 1'b1);
    check_idle("t4_after", e0 + 122);

    // Divisor change mid-frame only affects the next frame
    bus.baud_div = 16'd15;
    bus.trmt = 1'b1; bus.tx_data = 8'h96; step();
    e0 = cyc;
    bus.tx_data = 8'h0F; step();
    bus.trmt = 1'b0;
    steps(18);
    bus.baud_div = 16'd7;
    wait_idle("t5_idle", 600);
    steps(3);
    check_frame("t5_f1", e0 + 2,   8'h96, 15, 1'b0);
    check_frame("t5_f2", e0 + 162, 8'h0F, 7,  1'b1);
    check_idle("t5_after", e0 + 242);

    // Reset during data bit 4 with a second byte queued
    bus.baud_div = 16'd15;
    bus.trmt = 1'b1; bus.tx_data = 8'hC3; step();
    e0 = cyc;
    bus.tx_data = 8'h5A; step();
    bus.trmt = 1'b0;
    while (cyc < e0 + 2 + 85) step();
    chk("t6_tx_before_rst",   {31'd0, bus.TX},   32'd0);
    chk("t6_busy_before_rst", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_tx_async",   {31'd0, bus.TX},      32'd1);
    chk("t6_busy_async", {31'd0, bus.busy},    32'd0);
    chk("t6_done_async", {31'd0, bus.tx_done}, 32'd0);
    step();
    rst_n = 1'b1;
    r0 = cyc;
    steps(60);
    bad = 0;
    for (int i = r0 - 1; i < r0 + 58; i++) begin
      if (txlog[i] !== 1'b1 || donelog[i] !== 1'b0 || busylog[i] !== 1'b0) bad++;
    end
    chk("t6_quiet_after_rst_badclks", bad, 0);
    bus.baud_div = 16'd3;
    push(8'hE1);
    e0 = cyc;
    wait_idle("t6_idle", 400);
    steps(3);
    check_frame("t6_e1", e0 + 2, 8'hE1, 3, 1'b1);
    check_idle("t6_after", e0 + 42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
